dps_pixel_pair: RTL and testbench

- Synthesizable, cycle-accurate digital model of the 2-pixel digital pixel sensor.
- It is the responder to the pixel-array controller sequence (erase, expose, convert, read) and lets that sequence run against a real RTL target instead of analog stand-ins.
- Each pixel integrates a photocurrent into an accumulator during expose and latches the broadcast ramp code when its comparator trips during convert.
- On read, it returns the latched code on a point-to-point bus with an output enable; there is no tristate inside the block.

---
 rtl/dps_pkg.sv | 55 +++++
 rtl/dps_pixel_cell.sv | 96 +++++++++
 rtl/dps_pixel_pair.sv | 89 ++++++++
 tb/tb_dps_pixel_pair.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dps_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dps_pkg
//  Brief    : Shared types and constants for the 2-pixel digital pixel sensor.
//  Revision : 1.0 - initial release
// ============================================================================
package dps_pkg;

  localparam int unsigned c_DATA_W = 8;
  localparam int unsigned c_ACC_W  = 16;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_INTEG = 2'd1,
    P_CMP   = 2'd2,
    P_DONE  = 2'd3
  } cell_state_t;

  // Command that actually executes in a cycle after priority resolution.
  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_ERASE   = 3'd1,
    CMD_EXPOSE  = 3'd2,
    CMD_CONVERT = 3'd3,
    CMD_READ    = 3'd4
  } dps_cmd_t;

  function automatic dps_cmd_t dps_decode(
    input logic i_erase,
    input logic i_expose,
    input logic i_convert,
    input logic i_read
  );
    dps_cmd_t cmd;
    if (i_erase)        cmd = CMD_ERASE;
    else if (i_expose)  cmd = CMD_EXPOSE;
    else if (i_convert) cmd = CMD_CONVERT;
    else if (i_read)    cmd = CMD_READ;
    else                cmd = CMD_NONE;
    return cmd;
  endfunction

  function automatic logic dps_cmd_conflict(
    input logic i_erase,
    input logic i_expose,
    input logic i_convert,
    input logic i_read
  );
    logic [2:0] cnt;
    cnt = {2'b00, i_erase} + {2'b00, i_expose} + {2'b00, i_convert} + {2'b00, i_read};
    return (cnt > 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dps_pixel_cell.sv
`default_nettype none
// ============================================================================
//  Module   : dps_pixel_cell
//  Brief    : One pixel: photocurrent accumulator, ramp comparator, code latch.
//  Revision : 1.0 - initial release
// ============================================================================
module dps_pixel_cell
  import dps_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ACC_W  = c_ACC_W,
  parameter int unsigned RATE   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  dps_cmd_t          i_cmd,
  input  logic [DATA_W-1:0] i_ramp,
  output logic [DATA_W-1:0] o_code,
  output logic              o_expose_err
);

  localparam logic [ACC_W:0] c_RATE = (ACC_W+1)'(RATE);

  cell_state_t       r_state;
  cell_state_t       w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0] r_code;
  logic [DATA_W-1:0] w_code_nxt;
  logic              r_tripped;
  logic              w_tripped_nxt;

  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_sat;
  logic [DATA_W-1:0] w_level;
  logic              w_armable;

  // The extra carry bit flags overflow so the accumulator clamps instead of wrapping.
  assign w_sum     = {1'b0, r_acc} + c_RATE;
  assign w_acc_sat = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_level   = r_acc[ACC_W-1 -: DATA_W];
  assign w_armable = (r_state == P_IDLE) || (r_state == P_INTEG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= P_IDLE;
      r_acc     <= '0;
      r_code    <= '0;
      r_tripped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_code    <= w_code_nxt;
      r_tripped <= w_tripped_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_code_nxt    = r_code;
    w_tripped_nxt = r_tripped;

    if (i_cmd == CMD_ERASE) begin
      w_state_nxt   = P_IDLE;
      w_acc_nxt     = '0;
      w_code_nxt    = '0;
      w_tripped_nxt = 1'b0;
    end else if (r_state == P_CMP) begin
      if (i_cmd == CMD_CONVERT) begin
        if (!r_tripped && (i_ramp >= w_level)) begin
          w_code_nxt    = i_ramp;
          w_tripped_nxt = 1'b1;
        end
      end else begin
        // Convert no longer executing: the ramp is over, so an untripped
        // comparator reports the full-scale code.
        if (!r_tripped) begin
          w_code_nxt    = {DATA_W{1'b1}};
          w_tripped_nxt = 1'b1;
        end
        w_state_nxt = P_DONE;
      end
    end else if ((i_cmd == CMD_EXPOSE) && w_armable) begin
      w_state_nxt = P_INTEG;
      w_acc_nxt   = w_acc_sat;
    end else if ((i_cmd == CMD_CONVERT) && w_armable) begin
      w_state_nxt = P_CMP;
    end
  end

  assign o_code       = r_code;
  assign o_expose_err = (i_cmd == CMD_EXPOSE) && !w_armable;

endmodule
`default_nettype wire

// File: rtl/dps_pixel_pair.sv
`default_nettype none
// ============================================================================
//  Module   : dps_pixel_pair
//  Brief    : Two-pixel digital pixel sensor responder with registered readout.
//  Revision : 1.0 - initial release
// ============================================================================
module dps_pixel_pair
  import dps_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ACC_W  = c_ACC_W,
  parameter int unsigned RATE0  = 128,
  parameter int unsigned RATE1  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              expose,
  input  logic              convert,
  input  logic [DATA_W-1:0] ramp_code,
  input  logic              read1,
  input  logic              read2,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_oe,
  output logic              proto_err
);

  dps_cmd_t          w_cmd;
  logic              w_read_any;
  logic              w_err_set;
  logic [DATA_W-1:0] w_code0;
  logic [DATA_W-1:0] w_code1;
  logic              w_xerr0;
  logic              w_xerr1;

  assign w_read_any = read1 | read2;
  assign w_cmd      = dps_decode(erase, expose, convert, w_read_any);
  assign w_err_set  = dps_cmd_conflict(erase, expose, convert, w_read_any)
                    | (read1 & read2) | w_xerr0 | w_xerr1;

  dps_pixel_cell #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .RATE   (RATE0)
  ) u_cell0 (
    .clk          (clk),
    .reset        (reset),
    .i_cmd        (w_cmd),
    .i_ramp       (ramp_code),
    .o_code       (w_code0),
    .o_expose_err (w_xerr0)
  );

  dps_pixel_cell #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .RATE   (RATE1)
  ) u_cell1 (
    .clk          (clk),
    .reset        (reset),
    .i_cmd        (w_cmd),
    .i_ramp       (ramp_code),
    .o_code       (w_code1),
    .o_expose_err (w_xerr1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err <= 1'b0;
    end else if (w_err_set) begin
      proto_err <= 1'b1;
    end
  end

  // pix_data keeps its last value when the bus is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_data <= '0;
      pix_oe   <= 1'b0;
    end else if (w_cmd == CMD_READ) begin
      pix_data <= read1 ? w_code0 : w_code1;
      pix_oe   <= 1'b1;
    end else begin
      pix_oe   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dps_pixel_pair.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dps_pixel_pair
//  Brief    : Scoreboard bench for dps_pixel_pair (default rates and RATE0=300).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dps_pixel_pair;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       erase = 1'b0, expose = 1'b0, convert = 1'b0;
  logic       read1 = 1'b0, read2 = 1'b0;
  logic [7:0] ramp_code = 8'd0;

  logic [7:0] data_a, data_b;
  logic       oe_a, oe_b, err_a, err_b;

  always #5 clk = ~clk;

  dps_pixel_pair u_dut_a (
    .clk(clk), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
    .ramp_code(ramp_code), .read1(read1), .read2(read2),
    .pix_data(data_a), .pix_oe(oe_a), .proto_err(err_a)
  );

  dps_pixel_pair #(.RATE0(300)) u_dut_b (
    .clk(clk), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
    .ramp_code(ramp_code), .read1(read1), .read2(read2),
    .pix_data(data_b), .pix_oe(oe_b), .proto_err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: index [dut][pixel]; phase 0 idle, 1 integrating, 2 comparing, 3 done.
  int         m_rate  [2][2] = '{'{128, 64}, '{300, 64}};
  int         m_acc   [2][2];
  int         m_code  [2][2];
  bit         m_trip  [2][2];
  int         m_phase [2][2];
  bit         exp_err = 1'b0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        m_acc[d][p] = 0; m_code[d][p] = 0; m_trip[d][p] = 1'b0; m_phase[d][p] = 0;
      end
    exp_err = 1'b0;
  endfunction

  function automatic void model_step(input bit e, input bit x, input bit c,
                                     input bit r1, input bit r2, input int ramp);
    int nreq;
    nreq = int'(e) + int'(x) + int'(c) + int'(r1 | r2);
    if (nreq > 1 || (r1 && r2)) exp_err = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (nreq == 1 && (r1 || r2)) begin
        if (d == 0) q_a.push_back(8'(r1 ? m_code[0][0] : m_code[0][1]));
        else        q_b.push_back(8'(r1 ? m_code[1][0] : m_code[1][1]));
      end
      for (int p = 0; p < 2; p++) begin
        if (e) begin
          m_acc[d][p] = 0; m_code[d][p] = 0; m_trip[d][p] = 1'b0; m_phase[d][p] = 0;
        end else begin
          if (x && m_phase[d][p] >= 2) exp_err = 1'b1;
          if (m_phase[d][p] == 2) begin
            if (c && !x) begin
              if (!m_trip[d][p] && ramp >= m_acc[d][p] / 256) begin
                m_code[d][p] = ramp; m_trip[d][p] = 1'b1;
              end
            end else begin
              if (!m_trip[d][p]) begin
                m_code[d][p] = 255; m_trip[d][p] = 1'b1;
              end
              m_phase[d][p] = 3;
            end
          end else if (x) begin
            if (m_phase[d][p] < 2) begin
              m_phase[d][p] = 1;
              m_acc[d][p] = (m_acc[d][p] + m_rate[d][p] > 65535) ? 65535
                                                                  : m_acc[d][p] + m_rate[d][p];
            end
          end else if (c && m_phase[d][p] < 2) begin
            m_phase[d][p] = 2;
          end
        end
      end
    end
  endfunction

  task automatic cyc(input bit e, input bit x, input bit c,
                     input bit r1, input bit r2, input int ramp);
    erase = e; expose = x; convert = c; read1 = r1; read2 = r2;
    ramp_code = 8'(ramp);
    @(posedge clk);
    model_step(e, x, c, r1, r2, ramp);
    #1;
  endtask

  task automatic do_erase(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask
  task automatic do_expose(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
  endtask
  task automatic do_ramp(input int from, input int to, input int step);
    for (int v = from; v <= to; v += step) cyc(0, 0, 1, 0, 0, v);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare each driven readout against the queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (oe_a) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL oe_a_unexpected: got pix_oe=1 data=%0d expected no read", data_a);
        end else chk("rd_a", int'(data_a), int'(q_a.pop_front()));
      end
      if (oe_b) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL oe_b_unexpected: got pix_oe=1 data=%0d expected no read", data_b);
        end else chk("rd_b", int'(data_b), int'(q_b.pop_front()));
      end
      chk("err_a", int'(err_a), int'(exp_err));
      chk("err_b", int'(err_b), int'(exp_err));
    end
  end

  initial begin
    int nrd, start, step, len;
    model_reset();
    #12;
    chk("rst_data_a", int'(data_a), 0); chk("rst_oe_a", int'(oe_a), 0);
    chk("rst_err_a", int'(err_a), 0);   chk("rst_data_b", int'(data_b), 0);
    chk("rst_oe_b", int'(oe_b), 0);     chk("rst_err_b", int'(err_b), 0);
    reset = 1'b1;

    // Nominal frame: level 127 / 63; RATE0=300 saturates to level 255.
    do_erase(5); do_expose(255); do_ramp(1, 255, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("frame_r1_a", int'(data_a), 127); chk("frame_oe_a", int'(oe_a), 1);
    chk("frame_r1_b", int'(data_b), 255);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("frame_r2_a", int'(data_a), 63);  chk("frame_r2_b", int'(data_b), 63);
    cyc(0, 0, 0, 0, 0, 0);
    chk("release_oe_a", int'(oe_a), 0);   chk("hold_data_a", int'(data_a), 63);

    // Ramp stops at 254: saturated pixel never trips and reports full scale.
    do_erase(2); do_expose(255); do_ramp(1, 254, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("stop254_a", int'(data_a), 127);  chk("stop254_b", int'(data_b), 255);

    // Ramp runs past the trip point: first trip is kept.
    do_erase(2); do_expose(255); do_ramp(1, 200, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("past_trip_a", int'(data_a), 127);

    // Both reads together: pixel 0 wins and the error is sticky.
    cyc(0, 0, 0, 1, 1, 0);
    chk("dual_rd_a", int'(data_a), 127);  chk("dual_err_a", int'(err_a), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("sticky_err_a", int'(err_a), 1);

    // Asynchronous reset in the middle of a conversion.
    do_erase(2); do_expose(255);
    for (int v = 1; v <= 60; v++) cyc(0, 0, 1, 0, 0, v);
    reset = 1'b0;
    #1;
    chk("arst_data_a", int'(data_a), 0); chk("arst_err_a", int'(err_a), 0);
    chk("arst_data_b", int'(data_b), 0); chk("arst_err_b", int'(err_b), 0);
    model_reset();
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 1, 0, 0);
    chk("arst_read_a", int'(data_a), 0);

    // Expose after conversion without erase is an error and leaves the code alone.
    do_expose(255); do_ramp(1, 255, 1);
    chk("pre_xerr_a", int'(err_a), 0);
    do_expose(3);
    chk("xerr_a", int'(err_a), 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("xerr_code_a", int'(data_a), 127);
    do_erase(1); do_expose(255); do_ramp(1, 255, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("recover_a", int'(data_a), 127);

    // Randomized frames with occasional protocol noise.
    for (int it = 0; it < 20; it++) begin
      do_erase($urandom_range(1, 3));
      do_expose($urandom_range(0, 300));
      if ($urandom_range(0, 4) != 0) begin
        start = $urandom_range(0, 120);
        step  = $urandom_range(1, 4);
        len   = $urandom_range(1, 120);
        for (int i = 0; i < len; i++)
          cyc(0, 0, 1, 0, 0, (start + i * step > 255) ? 255 : start + i * step);
        cyc(0, 0, 0, 0, 0, 0);
      end
      nrd = $urandom_range(1, 4);
      for (int i = 0; i < nrd; i++) begin
        if ($urandom_range(0, 7) == 0) cyc(0, 0, 0, 1, 1, 0);
        else if ($urandom_range(0, 1) == 1) cyc(0, 0, 0, 1, 0, 0);
        else cyc(0, 0, 0, 0, 1, 0);
        if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 0, 0);
      end
      if ($urandom_range(0, 9) == 0)
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 255));
    end

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
